spart_mmio_responder: RTL and testbench

Memory-mapped bus responder that sits between the data-side memory bus and the SPART serial core. It decodes the two SPART registers: DATA at BASE_ADDR and STATUS at BASE_ADDR+1. It buffers received bytes in an RX FIFO and bytes to transmit in a TX FIFO. It answers every valid/ready bus transaction, including transactions to unmapped addresses, so polling initiators never hang.

---
 rtl/spart_mmio_responder_if.sv | 28 ++
 rtl/spart_mmio_responder.sv | 200 ++++++++++++++++++++
 tb/tb_spart_mmio_responder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_mmio_responder_if.sv
// Data-side memory bus between an initiator and the SPART MMIO responder.
// The initiator holds address, direction and write data with valid until it sees ready.
interface spart_mmio_responder_if;
    logic [27:0] mem_data_addr;
    logic        mem_rw;
    logic        mem_valid;
    logic [31:0] mem_data_wr;
    logic [31:0] mem_data_rd;
    logic        mem_ready;

    modport master (
        output mem_data_addr,
        output mem_rw,
        output mem_valid,
        output mem_data_wr,
        input  mem_data_rd,
        input  mem_ready
    );

    modport slave (
        input  mem_data_addr,
        input  mem_rw,
        input  mem_valid,
        input  mem_data_wr,
        output mem_data_rd,
        output mem_ready
    );
endinterface

// File: rtl/spart_mmio_responder.sv
// MMIO responder for the SPART core: DATA/STATUS registers backed by RX and TX FIFOs.
// Every bus command gets exactly one ready pulse, including commands to unmapped addresses.
module spart_mmio_responder #(
    parameter logic [27:0] BASE_ADDR = 28'h8000000,
    parameter int          RX_DEPTH  = 16,
    parameter int          TX_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    spart_mmio_responder_if.slave        bus,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam logic [27:0]      STATUS_ADDR = BASE_ADDR + 28'd1;
    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);
    localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        WAIT
    } state_t;

    state_t state;
    state_t state_next;
    logic        ready_next;
    logic [31:0] rd_next;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr;
    logic [RX_AW-1:0] rx_rd_ptr;
    logic [RX_CW-1:0] rx_count;
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr;
    logic [TX_AW-1:0] tx_rd_ptr;
    logic [TX_CW-1:0] tx_count;

    logic rx_overflow;
    logic tx_overflow;
    logic rx_underflow;

    logic accept;
    logic hit_data;
    logic hit_status;
    logic data_rd;
    logic data_wr;
    logic status_rd;
    logic status_wr;
    logic rx_empty;
    logic rx_full;
    logic tx_empty;
    logic tx_full;
    logic rx_pop;
    logic rx_push;
    logic tx_pop;
    logic tx_push;
    logic rx_ovf_set;
    logic rx_udf_set;
    logic tx_ovf_set;
    logic clr_rxo;
    logic clr_txo;
    logic clr_udf;
    logic [7:0]  rx_count8;
    logic [31:0] status_word;
    logic        unused_wr_bits;

    // A command is taken only from IDLE, so a held valid is never accepted twice.
    assign accept     = (state == IDLE) && bus.mem_valid;
    assign hit_data   = (bus.mem_data_addr == BASE_ADDR);
    assign hit_status = (bus.mem_data_addr == STATUS_ADDR);
    assign data_rd    = accept && hit_data && !bus.mem_rw;
    assign data_wr    = accept && hit_data && bus.mem_rw;
    assign status_rd  = accept && hit_status && !bus.mem_rw;
    assign status_wr  = accept && hit_status && bus.mem_rw;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == TX_FULL_CNT);

    // A same-cycle pop frees the slot a push into a full FIFO needs.
    assign rx_pop     = data_rd && !rx_empty;
    assign rx_push    = rx_valid && (!rx_full || rx_pop);
    assign rx_ovf_set = rx_valid && rx_full && !rx_pop;
    assign rx_udf_set = data_rd && rx_empty;
    assign tx_pop     = tx_valid && tx_ready;
    assign tx_push    = data_wr && (!tx_full || tx_pop);
    assign tx_ovf_set = data_wr && tx_full && !tx_pop;

    assign clr_rxo = status_wr && bus.mem_data_wr[2];
    assign clr_txo = status_wr && bus.mem_data_wr[3];
    assign clr_udf = status_wr && bus.mem_data_wr[4];
    assign unused_wr_bits = ^bus.mem_data_wr[31:8];

    assign rx_count8   = 8'(rx_count);
    assign status_word = {16'h0000, rx_count8, 3'b000, rx_underflow, tx_overflow,
                          rx_overflow, !rx_empty, !tx_full};

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_valid ? tx_mem[tx_rd_ptr] : 8'h00;

    always_comb begin
        state_next = state;
        ready_next = 1'b0;
        rd_next    = 32'h0000_0000;
        case (state)
            IDLE: begin
                if (bus.mem_valid) begin
                    ready_next = 1'b1;
                    state_next = RESP;
                    if (rx_pop) begin
                        rd_next = {24'h000000, rx_mem[rx_rd_ptr]};
                    end else if (status_rd) begin
                        rd_next = status_word;
                    end
                end
            end
            RESP: begin
                state_next = bus.mem_valid ? WAIT : IDLE;
            end
            WAIT: begin
                if (!bus.mem_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            bus.mem_ready   <= 1'b0;
            bus.mem_data_rd <= 32'h0000_0000;
        end else begin
            state           <= state_next;
            bus.mem_ready   <= ready_next;
            bus.mem_data_rd <= rd_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
            end
            rx_count <= rx_count + RX_CW'(rx_push) - RX_CW'(rx_pop);
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
            end
            tx_count <= tx_count + TX_CW'(tx_push) - TX_CW'(tx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= rx_data;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= bus.mem_data_wr[7:0];
        end
    end

    // A sticky set in the same cycle as its W1C clear must survive.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_overflow  <= 1'b0;
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            rx_overflow  <= rx_ovf_set || (rx_overflow && !clr_rxo);
            tx_overflow  <= tx_ovf_set || (tx_overflow && !clr_txo);
            rx_underflow <= rx_udf_set || (rx_underflow && !clr_udf);
        end
    end

endmodule

// File: tb/tb_spart_mmio_responder.sv
// Bench for spart_mmio_responder: directed register scenarios plus randomized bus/RX/TX traffic,
// checked every cycle against a queue-based model of the register and FIFO rules.
module tb_spart_mmio_responder;

    localparam logic [27:0] DATA_ADDR = 28'h8000000;
    localparam logic [27:0] STAT_ADDR = 28'h8000001;
    localparam logic [27:0] UNMAP     = 28'h0000010;
    localparam int          DEPTH     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;

    spart_mmio_responder_if bus();

    spart_mmio_responder #(
        .BASE_ADDR(DATA_ADDR),
        .RX_DEPTH (DEPTH),
        .TX_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit rand_side = 1'b0;
    int rx_rate = 3;
    int tx_rate = 4;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    bit          m_rxo = 1'b0;
    bit          m_txo = 1'b0;
    bit          m_udf = 1'b0;
    bit          m_armed = 1'b1;
    logic        m_ready = 1'b0;
    logic [31:0] m_rd = 32'h0;
    bit          m_acc;
    bit          m_txpop;
    bit          m_rxpop;
    int          m_rxsize;
    int          m_txsize;
    logic [7:0]  m_cnt8;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a command is taken when valid is seen and valid has dropped since the last one.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxq.delete();
            txq.delete();
            m_rxo = 1'b0;
            m_txo = 1'b0;
            m_udf = 1'b0;
            m_armed = 1'b1;
            m_ready = 1'b0;
            m_rd = 32'h0;
        end else begin
            m_acc = bus.mem_valid && m_armed;
            if (m_acc) m_armed = 1'b0;
            else if (!bus.mem_valid) m_armed = 1'b1;
            m_ready = m_acc;
            m_rd = 32'h0;
            m_rxsize = rxq.size();
            m_txsize = txq.size();
            m_cnt8 = 8'(m_rxsize);
            if (m_acc && bus.mem_data_addr == STAT_ADDR && !bus.mem_rw)
                m_rd = {16'h0, m_cnt8, 3'b000, m_udf, m_txo, m_rxo, m_rxsize != 0, m_txsize < DEPTH};
            if (m_acc && bus.mem_data_addr == STAT_ADDR && bus.mem_rw) begin
                if (bus.mem_data_wr[2]) m_rxo = 1'b0;
                if (bus.mem_data_wr[3]) m_txo = 1'b0;
                if (bus.mem_data_wr[4]) m_udf = 1'b0;
            end
            m_txpop = (m_txsize > 0) && tx_ready;
            if (m_txpop) void'(txq.pop_front());
            if (m_acc && bus.mem_data_addr == DATA_ADDR && bus.mem_rw) begin
                if (m_txsize < DEPTH || m_txpop) txq.push_back(bus.mem_data_wr[7:0]);
                else m_txo = 1'b1;
            end
            m_rxpop = 1'b0;
            if (m_acc && bus.mem_data_addr == DATA_ADDR && !bus.mem_rw) begin
                if (m_rxsize > 0) begin
                    m_rd = {24'h0, rxq.pop_front()};
                    m_rxpop = 1'b1;
                end else begin
                    m_udf = 1'b1;
                end
            end
            if (rx_valid) begin
                if (m_rxsize < DEPTH || m_rxpop) rxq.push_back(rx_data);
                else m_rxo = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        checkOutput("memReady", {31'h0, bus.mem_ready}, {31'h0, m_ready});
        checkOutput("memDataRd", bus.mem_data_rd, m_rd);
        checkOutput("txValid", {31'h0, tx_valid}, {31'h0, txq.size() != 0});
        checkOutput("txData", {24'h0, tx_data}, {24'h0, (txq.size() != 0) ? txq[0] : 8'h00});
    end

    task automatic tick();
        @(negedge clk);
        if (rand_side) begin
            rx_valid = ($urandom_range(0, rx_rate - 1) == 0);
            rx_data  = 8'($urandom);
            tx_ready = ($urandom_range(0, tx_rate - 1) == 0);
        end
    endtask

    task automatic applyStimulus(input logic [27:0] addr, input logic rw, input logic [31:0] wdata,
                                 input int hold, input logic rx_pulse, input logic [7:0] rx_byte,
                                 output logic [31:0] rdata);
        bit seen = 1'b0;
        int n = 0;
        rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_data_addr = addr;
        bus.mem_rw = rw;
        bus.mem_data_wr = wdata;
        bus.mem_valid = 1'b1;
        if (rx_pulse) begin
            rx_valid = 1'b1;
            rx_data = rx_byte;
        end
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.mem_ready) begin
                seen = 1'b1;
                rdata = bus.mem_data_rd;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL busTimeout: got no ready, expected ready within 20 cycles (addr %h)", addr);
        end
        tick();
        if (rx_pulse) rx_valid = 1'b0;
        repeat (hold) tick();
        bus.mem_valid = 1'b0;
        bus.mem_rw = 1'b0;
    endtask

    task automatic pushRx(input logic [7:0] b);
        tick();
        rx_valid = 1'b1;
        rx_data = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic resetDut();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic randomOp();
        int sel = $urandom_range(0, 9);
        logic [27:0] addr;
        logic rw;
        logic [31:0] wdata = $urandom;
        logic [31:0] rd;
        if (sel <= 2) begin addr = DATA_ADDR; rw = 1'b0; end
        else if (sel <= 5) begin addr = DATA_ADDR; rw = 1'b1; end
        else if (sel <= 7) begin addr = STAT_ADDR; rw = 1'b0; end
        else if (sel == 8) begin addr = STAT_ADDR; rw = 1'b1; end
        else begin addr = UNMAP + 28'($urandom_range(0, 100)); rw = 1'($urandom); end
        applyStimulus(addr, rw, wdata, $urandom_range(0, 2), 1'b0, 8'h00, rd);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    initial begin
        logic [31:0] rd;
        bus.mem_data_addr = 28'h0;
        bus.mem_rw = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_data_wr = 32'h0;
        #2 rst = 1'b0;
        #6;
        checkOutput("resetReady", {31'h0, bus.mem_ready}, 32'h0);
        checkOutput("resetDataRd", bus.mem_data_rd, 32'h0);
        checkOutput("resetTxValid", {31'h0, tx_valid}, 32'h0);
        checkOutput("resetTxData", {24'h0, tx_data}, 32'h0);
        tick();
        rst = 1'b1;

        applyStimulus(STAT_ADDR, 1'b0, 32'h0, 3, 1'b0, 8'h00, rd);
        checkOutput("statusAfterReset", rd, 32'h0000_0001);

        pushRx(8'hA5);
        pushRx(8'h3C);
        applyStimulus(STAT_ADDR, 1'b0, 32'h0, 0, 1'b0, 8'h00, rd);
        checkOutput("statusTwoRx", rd, 32'h0000_0203);
        applyStimulus(DATA_ADDR, 1'b0, 32'h0, 0, 1'b0, 8'h00, rd);
        checkOutput("dataRead0", rd, 32'h0000_00A5);
        applyStimulus(DATA_ADDR, 1'b0, 32'h0, 1, 1'b0, 8'h00, rd);
        checkOutput("dataRead1", rd, 32'h0000_003C);
        applyStimulus(STAT_ADDR, 1'b0, 32'h0, 0, 1'b0, 8'h00, rd);
        checkOutput("statusDrained", rd, 32'h0000_0001);

        applyStimulus(DATA_ADDR, 1'b1, 32'h1234_5655, 0, 1'b0, 8'h00, rd);
        checkOutput("txValidAfterWrite", {31'h0, tx_valid}, 32'h1);
        checkOutput("txDataAfterWrite", {24'h0, tx_data}, 32'h55);
        tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        checkOutput("txValidAfterPop", {31'h0, tx_valid}, 32'h0);

        for (int i = 0; i < 17; i++) pushRx(8'(i));
        checkOutput("modelRxCount", rxq.size(), 32'd16);
        checkOutput("modelRxOvf", {31'h0, m_rxo}, 32'h1);
        applyStimulus(STAT_ADDR, 1'b0, 32'h0, 0, 1'b0, 8'h00, rd);
        checkOutput("statusRxFullOvf", rd, 32'h0000_1007);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(DATA_ADDR, 1'b0, 32'h0, 0, 1'b0, 8'h00, rd);
            checkOutput("rxFifoOrder", rd, 32'(i));
        end
        applyStimulus(STAT_ADDR, 1'b1, 32'h0000_0004, 0, 1'b0, 8'h00, rd);
        applyStimulus(STAT_ADDR, 1'b0, 32'h0, 0, 1'b0, 8'h00, rd);
        checkOutput("statusOvfCleared", rd, 32'h0000_0001);

        resetDut();
        for (int i = 0; i < 16; i++) pushRx(8'h20 + 8'(i));
        applyStimulus(DATA_ADDR, 1'b0, 32'h0, 0, 1'b1, 8'hEE, rd);
        checkOutput("fullPushPopRead", rd, 32'h0000_0020);
        applyStimulus(STAT_ADDR, 1'b0, 32'h0, 0, 1'b0, 8'h00, rd);
        checkOutput("fullPushPopStatus", rd, 32'h0000_1003);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(DATA_ADDR, 1'b0, 32'h0, 0, 1'b0, 8'h00, rd);
            checkOutput("fullPushPopOrder", rd, (i == 15) ? 32'h0000_00EE : 32'h21 + 32'(i));
        end

        pushRx(8'h11);
        applyStimulus(DATA_ADDR, 1'b1, 32'h0000_0099, 0, 1'b0, 8'h00, rd);
        checkOutput("txValidBeforeReset", {31'h0, tx_valid}, 32'h1);
        tick();
        bus.mem_data_addr = UNMAP;
        bus.mem_rw = 1'b0;
        bus.mem_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("unmappedReady", {31'h0, bus.mem_ready}, 32'h1);
        checkOutput("unmappedData", bus.mem_data_rd, 32'h0);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        checkOutput("midResetReady", {31'h0, bus.mem_ready}, 32'h0);
        checkOutput("midResetTxValid", {31'h0, tx_valid}, 32'h0);
        checkOutput("midResetTxData", {24'h0, tx_data}, 32'h0);
        tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reacceptAfterReset", {31'h0, bus.mem_ready}, 32'h1);
        tick();
        bus.mem_valid = 1'b0;
        tick();
        applyStimulus(STAT_ADDR, 1'b0, 32'h0, 0, 1'b0, 8'h00, rd);
        checkOutput("statusAfterMidReset", rd, 32'h0000_0001);

        rand_side = 1'b1;
        rx_rate = 3;
        tx_rate = 4;
        for (int i = 0; i < 250; i++) randomOp();
        rx_rate = 8;
        tx_rate = 2;
        for (int i = 0; i < 250; i++) randomOp();
        rand_side = 1'b0;
        tick();
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        checks++;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 1000000 time units");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
